phase_sequencer: RTL and testbench

//  Receiving end of the five-phase clock interface driven by the run/stop controller.

---
 rtl/phase_sequencer.sv | 153 +++++++++++++++
 tb/tb_phase_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Receiving end of the five-phase clock interface: tracks the instruction stage from the
// phase strobes, checks their ordering, counts retired instructions and raises stop requests.
module phase_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       phase_in,
  input  logic             halt_req,
  input  logic             stop_ack,
  output logic [2:0]       stage,
  output logic [4:0]       stage_onehot,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             stop_req,
  output logic             seq_error,
  output logic [1:0]       err_code
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_P0   = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_P4   = 3'd4,
    ST_IDLE = 3'd7
  } stage_e;

  stage_e           stage_q, stage_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [4:0]       onehot_q, onehot_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic             is_none, is_one, accept4, err_hit;
  logic [2:0]       one_idx;
  logic [1:0]       err_new;

  // Strobe classification: none, exactly one (with its index), or several
  always_comb begin
    is_none = (phase_in == 5'd0);
    is_one  = !is_none && ((phase_in & (phase_in - 5'd1)) == 5'd0);
    one_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (phase_in[i]) one_idx = 3'(i);
    end
  end

  // Stage transitions, gap timing and error detection
  always_comb begin
    stage_d = stage_q;
    gap_d   = gap_q;
    accept4 = 1'b0;
    err_hit = 1'b0;
    err_new = 2'd0;
    case (stage_q)
      ST_IDLE: begin
        if (is_one && one_idx == 3'd0) begin
          stage_d = ST_P0;
          gap_d   = '0;
        end
      end
      ST_P4: begin
        if (is_one && one_idx == 3'd0) begin
          stage_d = ST_P0;
          gap_d   = '0;
        end else if (!is_none) begin
          stage_d = ST_IDLE;
          gap_d   = '0;
          err_hit = 1'b1;
          err_new = 2'd2;
        end
      end
      default: begin
        if (is_one && one_idx == stage_q + 3'd1) begin
          stage_d = stage_e'(one_idx);
          gap_d   = '0;
          accept4 = (one_idx == 3'd4);
        end else if (is_none) begin
          if (gap_q >= GAP_W'(TIMEOUT - 1)) begin
            stage_d = ST_IDLE;
            gap_d   = '0;
            err_hit = 1'b1;
            err_new = 2'd3;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else if (is_one && one_idx == 3'd0) begin
          stage_d = ST_P0;
          gap_d   = '0;
          err_hit = 1'b1;
          err_new = 2'd1;
        end else begin
          stage_d = ST_IDLE;
          gap_d   = '0;
          err_hit = 1'b1;
          err_new = 2'd2;
        end
      end
    endcase
  end

  // Output-side next values: retire count, stop handshake, sticky first-error capture
  always_comb begin
    onehot_d = 5'd0;
    if (stage_d != ST_IDLE) onehot_d = 5'd1 << stage_d;
    done_d = accept4;
    cnt_d  = cnt_q;
    if (accept4) cnt_d = cnt_q + CNT_W'(1);
    if (stop_q) stop_d = !stop_ack;
    else        stop_d = accept4 && halt_req;
    err_d  = err_q | err_hit;
    code_d = code_q;
    if (err_hit && !err_q) code_d = err_new;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q  <= ST_IDLE;
      gap_q    <= '0;
      onehot_q <= 5'd0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      stage_q  <= stage_d;
      gap_q    <= gap_d;
      onehot_q <= onehot_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign stage        = stage_q;
  assign stage_onehot = onehot_q;
  assign instr_done   = done_q;
  assign instr_count  = cnt_q;
  assign stop_req     = stop_q;
  assign seq_error    = err_q;
  assign err_code     = code_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a behavioural model pushes expected outputs per
// driven cycle; they are popped and compared one cycle later. A CNT_W=4 copy checks wrap.
module tb_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  phase_in = 5'd0;
  logic        halt_req = 1'b0;
  logic        stop_ack = 1'b0;

  logic [2:0]  stage, stage4;
  logic [4:0]  stage_onehot, stage_onehot4;
  logic        instr_done, instr_done4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;
  logic        stop_req, stop_req4;
  logic        seq_error, seq_error4;
  logic [1:0]  err_code, err_code4;

  always #5 clock = ~clock;

  phase_sequencer #(.CNT_W(16), .TIMEOUT(15)) u_dut (
    .clock(clock), .reset_n(reset_n), .phase_in(phase_in), .halt_req(halt_req),
    .stop_ack(stop_ack), .stage(stage), .stage_onehot(stage_onehot),
    .instr_done(instr_done), .instr_count(instr_count), .stop_req(stop_req),
    .seq_error(seq_error), .err_code(err_code)
  );

  phase_sequencer #(.CNT_W(4), .TIMEOUT(15)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .phase_in(phase_in), .halt_req(halt_req),
    .stop_ack(stop_ack), .stage(stage4), .stage_onehot(stage_onehot4),
    .instr_done(instr_done4), .instr_count(instr_count4), .stop_req(stop_req4),
    .seq_error(seq_error4), .err_code(err_code4)
  );

  typedef struct {
    int         stage;
    logic [4:0] oh;
    logic       done;
    int         cnt;
    int         cnt4;
    logic       stop;
    logic       err;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done_seen = 0;

  // Reference model state; stage -1 stands for IDLE
  int         m_stage, m_gap, m_cnt;
  logic       m_stop, m_err, m_done;
  logic [1:0] m_code;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_stage = -1; m_gap = 0; m_cnt = 0;
    m_stop = 1'b0; m_err = 1'b0; m_done = 1'b0; m_code = 2'd0;
  endfunction

  function automatic void flag_error(input logic [1:0] code);
    if (!m_err) m_code = code;
    m_err = 1'b1;
  endfunction

  function automatic void model_step(input logic [4:0] p, input logic h, input logic a);
    int   n = $countones(p);
    int   k = -1;
    logic took4 = 1'b0;
    for (int i = 0; i < 5; i++) if (p[i]) k = i;
    if (m_stage == -1) begin
      if (n == 1 && k == 0) begin m_stage = 0; m_gap = 0; end
    end else if (m_stage == 4) begin
      if (n == 1 && k == 0) begin m_stage = 0; m_gap = 0; end
      else if (n != 0) begin m_stage = -1; m_gap = 0; flag_error(2'd2); end
    end else if (n == 1 && k == m_stage + 1) begin
      m_stage = k; m_gap = 0; took4 = (k == 4);
    end else if (n == 0) begin
      m_gap++;
      if (m_gap >= 15) begin m_stage = -1; m_gap = 0; flag_error(2'd3); end
    end else if (n == 1 && k == 0) begin
      m_stage = 0; m_gap = 0; flag_error(2'd1);
    end else begin
      m_stage = -1; m_gap = 0; flag_error(2'd2);
    end
    if (m_stop) begin
      if (a) m_stop = 1'b0;
    end else if (took4 && h) begin
      m_stop = 1'b1;
    end
    m_done = took4;
    if (took4) m_cnt++;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.stage = (m_stage < 0) ? 7 : m_stage;
    e.oh    = 5'd0;
    for (int i = 0; i < 5; i++) if (i == m_stage) e.oh[i] = 1'b1;
    e.done  = m_done;
    e.cnt   = m_cnt % 65536;
    e.cnt4  = m_cnt % 16;
    e.stop  = m_stop;
    e.err   = m_err;
    e.code  = m_code;
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    expect_eq({tag, " stage"},  32'(stage),        e.stage);
    expect_eq({tag, " onehot"}, 32'(stage_onehot), 32'(e.oh));
    expect_eq({tag, " done"},   32'(instr_done),   32'(e.done));
    expect_eq({tag, " count"},  32'(instr_count),  e.cnt);
    expect_eq({tag, " count4"}, 32'(instr_count4), e.cnt4);
    expect_eq({tag, " stop"},   32'(stop_req),     32'(e.stop));
    expect_eq({tag, " err"},    32'(seq_error),    32'(e.err));
    expect_eq({tag, " code"},   32'(err_code),     32'(e.code));
  endtask

  // Drive one cycle of stimulus, predict, then compare what the DUT shows after the edge
  task automatic step(input logic [4:0] p, input logic h, input logic a);
    exp_t e;
    @(negedge clock);
    phase_in = p; halt_req = h; stop_ack = a;
    model_step(p, h, a);
    exp_q.push_back(snapshot());
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      expect_eq("scoreboard empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      compare_all("cyc", e);
    end
    if (instr_done) n_done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 1'b0, 1'b0);
  endtask

  task automatic run_instr(input logic h, input logic a);
    for (int ph = 0; ph < 4; ph++) begin
      step(5'd1 << ph, 1'b0, 1'b0);
      idle(1);
    end
    step(5'b10000, h, a);
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; phase_in = 5'd0; halt_req = 1'b0; stop_ack = 1'b0;
    #1;
    model_reset();
    compare_all("reset", snapshot());
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // 1: one clean instruction
    do_reset();
    run_instr(1'b0, 1'b0);
    expect_eq("t1 count", 32'(instr_count), 32'd1);
    expect_eq("t1 seq_error", 32'(seq_error), 32'd0);

    // 2: stop handshake on the third instruction's halt
    do_reset();
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b1);
    for (int ph = 0; ph < 4; ph++) begin
      step(5'd1 << ph, 1'b1, 1'b0);
      idle(1);
    end
    step(5'b10000, 1'b1, 1'b0);
    expect_eq("t2 stop rise", 32'(stop_req), 32'd1);
    idle(4);
    expect_eq("t2 stop held", 32'(stop_req), 32'd1);
    step(5'd0, 1'b0, 1'b1);
    expect_eq("t2 stop fall", 32'(stop_req), 32'd0);
    expect_eq("t2 count", 32'(instr_count), 32'd3);
    run_instr(1'b1, 1'b0);
    run_instr(1'b1, 1'b1);
    expect_eq("t2 ack with new halt", 32'(stop_req), 32'd0);

    // 3: early phase0, then illegal strobe keeps first code
    do_reset();
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0);
    step(5'b00001, 1'b0, 1'b0);
    expect_eq("t3 code1", 32'(err_code), 32'd1);
    expect_eq("t3 stage0", 32'(stage), 32'd0);
    step(5'b01000, 1'b0, 1'b0);
    expect_eq("t3 code kept", 32'(err_code), 32'd1);
    expect_eq("t3 idle", 32'(stage), 32'd7);

    // 4: timeout, then a long stage-4 hold with no error
    do_reset();
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0);
    idle(14);
    expect_eq("t4 not yet", 32'(stage), 32'd1);
    idle(1);
    expect_eq("t4 timeout idle", 32'(stage), 32'd7);
    expect_eq("t4 code3", 32'(err_code), 32'd3);
    do_reset();
    for (int ph = 0; ph < 5; ph++) step(5'd1 << ph, 1'b0, 1'b0);
    idle(100);
    expect_eq("t4 stage4 hold", 32'(stage), 32'd4);
    expect_eq("t4 no error", 32'(seq_error), 32'd0);

    // 5: counter wrap on the narrow copy, then a multi-bit strobe
    do_reset();
    n_done_seen = 0;
    for (int i = 0; i < 16; i++) run_instr(1'b0, 1'b0);
    expect_eq("t5 wrap", 32'(instr_count4), 32'd0);
    expect_eq("t5 done pulses", n_done_seen, 32'd16);
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0);
    step(5'b00110, 1'b0, 1'b0);
    expect_eq("t5 code2", 32'(err_code), 32'd2);

    // 6: asynchronous reset while a stop request is pending at stage 3
    do_reset();
    run_instr(1'b1, 1'b0);
    for (int ph = 0; ph < 4; ph++) step(5'd1 << ph, 1'b0, 1'b0);
    expect_eq("t6 pre stop", 32'(stop_req), 32'd1);
    expect_eq("t6 pre stage", 32'(stage), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("t6 async", snapshot());
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);

    expect_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
